// File: rtl/lookup_type_pipe_if.sv
// Lookup request / result handshake bundle for lookup_type_pipe.
// The master drives requests and result ready; the slave returns results.
interface lookup_type_pipe_if #(
  parameter int unsigned TYPE_NUM     = 4,
  parameter int unsigned TYPE_WIDTH   = 16,
  parameter int unsigned RULE_NUM     = 16,
  parameter int unsigned RESULT_WIDTH = 64,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned IDX_WIDTH    = $clog2(RULE_NUM + 1)
);

  logic                           lkp_valid;
  logic                           lkp_ready;
  logic [TYPE_NUM*TYPE_WIDTH-1:0] lkp_type;
  logic [TAG_WIDTH-1:0]           lkp_tag;

  logic                           res_valid;
  logic                           res_ready;
  logic                           res_hit;
  logic [IDX_WIDTH-1:0]           res_idx;
  logic [RESULT_WIDTH-1:0]        res_data;
  logic [TAG_WIDTH-1:0]           res_tag;

  modport master (
    output lkp_valid,
    output lkp_type,
    output lkp_tag,
    output res_ready,
    input  lkp_ready,
    input  res_valid,
    input  res_hit,
    input  res_idx,
    input  res_data,
    input  res_tag
  );

  modport slave (
    input  lkp_valid,
    input  lkp_type,
    input  lkp_tag,
    input  res_ready,
    output lkp_ready,
    output res_valid,
    output res_hit,
    output res_idx,
    output res_data,
    output res_tag
  );

endinterface

// File: rtl/lookup_type_pipe.sv
// Two-stage ternary type lookup: S1 registers the per-rule hit vector, S2 picks the
// lowest-index hit and returns its result word; per-rule and miss hit counters.
module lookup_type_pipe #(
  parameter int unsigned TYPE_NUM     = 4,
  parameter int unsigned TYPE_WIDTH   = 16,
  parameter int unsigned RULE_NUM     = 16,
  parameter int unsigned RESULT_WIDTH = 64,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned IDX_WIDTH    = $clog2(RULE_NUM + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,

  lookup_type_pipe_if.slave              lkp,

  input  logic                           i_cfg_wren,
  output logic                           o_cfg_ready,
  input  logic [IDX_WIDTH-1:0]           i_cfg_idx,
  input  logic                           i_cfg_valid,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_cfg_data,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_cfg_mask,
  input  logic [RESULT_WIDTH-1:0]        i_cfg_result,

  input  logic                           i_dflt_wren,
  input  logic [RESULT_WIDTH-1:0]        i_dflt_result,

  input  logic                           i_cnt_rden,
  input  logic [IDX_WIDTH-1:0]           i_cnt_idx,
  input  logic                           i_cnt_clr,
  output logic                           o_cnt_valid,
  output logic [CNT_WIDTH-1:0]           o_cnt_data
);

  localparam int unsigned KeyWidth = TYPE_NUM * TYPE_WIDTH;
  localparam int unsigned CntNum   = RULE_NUM + 1;

  // Rule table
  logic [RULE_NUM-1:0]     rule_valid_q;
  logic [KeyWidth-1:0]     rule_data_q   [RULE_NUM];
  logic [KeyWidth-1:0]     rule_mask_q   [RULE_NUM];
  logic [RESULT_WIDTH-1:0] rule_result_q [RULE_NUM];
  logic [RESULT_WIDTH-1:0] dflt_q;

  // Pipeline state
  logic                    s1_valid_q;
  logic [RULE_NUM-1:0]     s1_hit_q;
  logic [TAG_WIDTH-1:0]    s1_tag_q;
  logic                    res_valid_q;
  logic                    res_hit_q;
  logic [IDX_WIDTH-1:0]    res_idx_q;
  logic [RESULT_WIDTH-1:0] res_data_q;
  logic [TAG_WIDTH-1:0]    res_tag_q;

  // Counters; entry RULE_NUM counts misses
  logic [CNT_WIDTH-1:0]    cnt_q [CntNum];
  logic [CNT_WIDTH-1:0]    cnt_d [CntNum];
  logic                    cnt_valid_q;
  logic [CNT_WIDTH-1:0]    cnt_data_q;
  logic [CNT_WIDTH-1:0]    cnt_rd;

  logic                    advance;
  logic                    lkp_fire;
  logic                    res_fire;
  logic                    cfg_we;
  logic [RULE_NUM-1:0]     hit_vec;
  logic                    win_hit;
  logic [IDX_WIDTH-1:0]    win_idx;
  logic [RESULT_WIDTH-1:0] win_data;

  assign advance     = ~res_valid_q | lkp.res_ready;
  assign lkp_fire    = lkp.lkp_valid & advance;
  assign res_fire    = res_valid_q & lkp.res_ready;
  // Writes only land on an empty pipeline, so no in-flight hit vector goes stale.
  assign o_cfg_ready = ~s1_valid_q & ~res_valid_q & ~lkp.lkp_valid;
  assign cfg_we      = i_cfg_wren & o_cfg_ready & (i_cfg_idx < IDX_WIDTH'(RULE_NUM));

  assign lkp.lkp_ready = advance;
  assign lkp.res_valid = res_valid_q;
  assign lkp.res_hit   = res_hit_q;
  assign lkp.res_idx   = res_idx_q;
  assign lkp.res_data  = res_data_q;
  assign lkp.res_tag   = res_tag_q;
  assign o_cnt_valid   = cnt_valid_q;
  assign o_cnt_data    = cnt_data_q;

  // Ternary match; a mask bit of 1 compares the bit, 0 makes it don't-care.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < RULE_NUM; i++) begin
      hit_vec[i] = rule_valid_q[i] &
                   (((lkp.lkp_type ^ rule_data_q[i]) & rule_mask_q[i]) == '0);
    end
  end

  // Descending scan so the lowest set index is the last to assign.
  always_comb begin
    win_hit  = 1'b0;
    win_idx  = IDX_WIDTH'(RULE_NUM);
    win_data = dflt_q;
    for (int i = RULE_NUM - 1; i >= 0; i--) begin
      if (s1_hit_q[i]) begin
        win_hit  = 1'b1;
        win_idx  = IDX_WIDTH'(i);
        win_data = rule_result_q[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rule_valid_q <= '0;
      dflt_q       <= '0;
      for (int i = 0; i < RULE_NUM; i++) begin
        rule_data_q[i]   <= '0;
        rule_mask_q[i]   <= '0;
        rule_result_q[i] <= '0;
      end
    end else begin
      if (i_dflt_wren) begin
        dflt_q <= i_dflt_result;
      end
      for (int i = 0; i < RULE_NUM; i++) begin
        if (cfg_we && (i_cfg_idx == IDX_WIDTH'(i))) begin
          rule_valid_q[i]  <= i_cfg_valid;
          rule_data_q[i]   <= i_cfg_data;
          rule_mask_q[i]   <= i_cfg_mask;
          rule_result_q[i] <= i_cfg_result;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= '0;
      s1_tag_q    <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else if (advance) begin
      s1_valid_q  <= lkp.lkp_valid;
      res_valid_q <= s1_valid_q;
      if (lkp_fire) begin
        s1_hit_q <= hit_vec;
        s1_tag_q <= lkp.lkp_tag;
      end
      if (s1_valid_q) begin
        res_hit_q  <= win_hit;
        res_idx_q  <= win_idx;
        res_data_q <= win_data;
        res_tag_q  <= s1_tag_q;
      end
    end
  end

  // A clear coinciding with an increment leaves the counter at 1.
  always_comb begin
    for (int k = 0; k < CntNum; k++) begin
      cnt_d[k] = cnt_q[k];
      if (i_cnt_rden && i_cnt_clr && (i_cnt_idx == IDX_WIDTH'(k))) begin
        cnt_d[k] = (res_fire && (res_idx_q == IDX_WIDTH'(k))) ? CNT_WIDTH'(1) : '0;
      end else if (res_fire && (res_idx_q == IDX_WIDTH'(k)) && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    cnt_rd = '0;
    for (int k = 0; k < CntNum; k++) begin
      if (i_cnt_idx == IDX_WIDTH'(k)) begin
        cnt_rd = cnt_q[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < CntNum; k++) begin
        cnt_q[k] <= '0;
      end
      cnt_valid_q <= 1'b0;
      cnt_data_q  <= '0;
    end else begin
      for (int k = 0; k < CntNum; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      cnt_valid_q <= i_cnt_rden;
      if (i_cnt_rden) begin
        cnt_data_q <= cnt_rd;
      end
    end
  end

endmodule
